multi_clk_divider: RTL and testbench

- Parametrised, multi-channel successor to the team's single-output programmable clock divider.
- Generates NUM_CH independent 50%-duty divided clock enables/levels from one input clock.
- Each channel has its own divisor, enable and per-toggle TICK strobe.
- Divisor updates are shadow-loaded only at half-period boundaries (glitch-free), and a global SYNC re-aligns all channels.
- Sits between the board clock and slower peripheral/LED/UART timing logic.

---
 rtl/div_pkg.sv | 20 ++
 rtl/clk_div_channel.sv | 48 ++++
 rtl/multi_clk_divider.sv | 39 +++
 tb/tb_multi_clk_divider.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and divisor-slicing helper for the multi-channel clock divider
package div_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_CH = 2;
    localparam int MAX_WIDTH  = 32;
    localparam int MAX_BUS    = 1024;

    // Extracts channel ch's divisor of the given width from a zero-extended flat bus.
    function automatic logic [MAX_WIDTH-1:0] div_slice(
        input logic [MAX_BUS-1:0] bus,
        input int                 ch,
        input int                 width
    );
        logic [MAX_BUS-1:0] shifted;
        shifted = bus >> (ch * width);
        return shifted[MAX_WIDTH-1:0] & ~({MAX_WIDTH{1'b1}} << width);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one 50%-duty divider channel with shadow-loaded divisor and toggle tick
module clk_div_channel
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             EN,
    input  logic             SYNC,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             CLK_OUT,
    output logic             TICK
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_div;
    logic             boundary;

    // >= also ends the half-period if a smaller divisor was reloaded while the channel sat disabled
    assign boundary = (cnt >= act_div);

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            cnt     <= '0;
            act_div <= '0;
            CLK_OUT <= 1'b0;
            TICK    <= 1'b0;
        end else if (SYNC) begin
            cnt     <= '0;
            act_div <= DIVISOR;
            CLK_OUT <= 1'b0;
            TICK    <= 1'b0;
        end else if (!EN) begin
            act_div <= DIVISOR;
            TICK    <= 1'b0;
        end else if (boundary) begin
            cnt     <= '0;
            act_div <= DIVISOR;
            CLK_OUT <= ~CLK_OUT;
            TICK    <= 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
            TICK    <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_clk_divider.sv
// rtl/multi_clk_divider.sv - NUM_CH independent programmable clock dividers sharing one clock, reset and sync
module multi_clk_divider
    import div_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                    CLK_IN,
    input  logic                    RST,
    input  logic [NUM_CH-1:0]       EN,
    input  logic                    SYNC,
    input  logic [NUM_CH*WIDTH-1:0] DIVISOR,
    output logic [NUM_CH-1:0]       CLK_OUT,
    output logic [NUM_CH-1:0]       TICK
);

    logic [MAX_BUS-1:0] divisor_bus;

    assign divisor_bus = MAX_BUS'(DIVISOR);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] ch_div;

        assign ch_div = WIDTH'(div_slice(divisor_bus, i, WIDTH));

        clk_div_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .CLK_IN (CLK_IN),
            .RST    (RST),
            .EN     (EN[i]),
            .SYNC   (SYNC),
            .DIVISOR(ch_div),
            .CLK_OUT(CLK_OUT[i]),
            .TICK   (TICK[i])
        );
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// tb/tb_multi_clk_divider.sv - self-checking bench for multi_clk_divider (WIDTH=4, NUM_CH=2)
module tb_multi_clk_divider;

    localparam int W  = 4;
    localparam int NC = 2;

    logic            CLK_IN = 1'b0;
    logic            RST;
    logic [NC-1:0]   EN;
    logic            SYNC;
    logic [NC*W-1:0] DIVISOR;
    logic [NC-1:0]   CLK_OUT;
    logic [NC-1:0]   TICK;

    int passed = 0;
    int total  = 0;

    multi_clk_divider #(.WIDTH(W), .NUM_CH(NC)) dut (
        .CLK_IN (CLK_IN),
        .RST    (RST),
        .EN     (EN),
        .SYNC   (SYNC),
        .DIVISOR(DIVISOR),
        .CLK_OUT(CLK_OUT),
        .TICK   (TICK)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    endtask

    // Model: each channel's half-period lasts (captured divisor + 1) enabled edges;
    // progress tracks enabled edges spent in the current half-period.
    int progress [NC];
    int half_len [NC];
    bit lvl      [NC];
    bit tck      [NC];

    always @(posedge CLK_IN or posedge RST) begin
        for (int i = 0; i < NC; i++) begin
            if (RST) begin
                progress[i] = 0; half_len[i] = 1; lvl[i] = 0; tck[i] = 0;
            end else if (SYNC) begin
                progress[i] = 0; half_len[i] = int'(DIVISOR[i*W +: W]) + 1; lvl[i] = 0; tck[i] = 0;
            end else if (!EN[i]) begin
                half_len[i] = int'(DIVISOR[i*W +: W]) + 1; tck[i] = 0;
            end else if (progress[i] + 1 >= half_len[i]) begin
                progress[i] = 0; half_len[i] = int'(DIVISOR[i*W +: W]) + 1;
                lvl[i] = ~lvl[i]; tck[i] = 1;
            end else begin
                progress[i]++; tck[i] = 0;
            end
        end
    end

    always @(negedge CLK_IN) begin
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("model_clk_out%0d", i), int'(CLK_OUT[i]), int'(lvl[i]));
            chk($sformatf("model_tick%0d", i), int'(TICK[i]), int'(tck[i]));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK_IN);
            #1;
        end
    endtask

    task automatic sync_pulse();
        SYNC = 1'b1;
        step(1);
        SYNC = 1'b0;
    endtask

    int ticks0;
    int first0;

    initial begin
        RST = 1'b1; EN = '0; SYNC = 1'b0; DIVISOR = '0;
        step(2);
        chk("reset_clk_out", int'(CLK_OUT), 0);
        chk("reset_tick", int'(TICK), 0);

        // Basic rates: ch0 div 0, ch1 div 2
        DIVISOR = {4'd2, 4'd0}; EN = 2'b11; RST = 1'b0;
        step(1); chk("rate_e1_clk", int'(CLK_OUT), 3); chk("rate_e1_tick", int'(TICK), 3);
        step(1); chk("rate_e2_clk", int'(CLK_OUT), 2); chk("rate_e2_tick", int'(TICK), 1);
        step(1); chk("rate_e3_clk", int'(CLK_OUT), 3); chk("rate_e3_tick", int'(TICK), 1);
        step(1); chk("rate_e4_clk", int'(CLK_OUT), 0); chk("rate_e4_tick", int'(TICK), 3);
        step(2); chk("rate_e6_clk", int'(CLK_OUT), 0);
        step(1); chk("rate_e7_clk", int'(CLK_OUT), 3);

        // Async reset between edges
        #2 RST = 1'b1;
        #1 chk("async_rst_clk", int'(CLK_OUT), 0); chk("async_rst_tick", int'(TICK), 0);
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("rst_hold_clk", int'(CLK_OUT), 0);
            chk("rst_hold_tick", int'(TICK), 0);
        end
        RST = 1'b0;

        // Shadow load: ch0 div 3, changed to 1 at cnt=1
        DIVISOR = {4'd0, 4'd3}; EN = 2'b11;
        sync_pulse();
        chk("shadow_sync_clk0", int'(CLK_OUT[0]), 0);
        step(1); DIVISOR = {4'd0, 4'd1};
        step(2); chk("shadow_e3", int'(CLK_OUT[0]), 0);
        step(1); chk("shadow_e4", int'(CLK_OUT[0]), 1); chk("shadow_e4_tick", int'(TICK[0]), 1);
        step(1); chk("shadow_e5", int'(CLK_OUT[0]), 1);
        step(1); chk("shadow_e6", int'(CLK_OUT[0]), 0);
        step(1); chk("shadow_e7", int'(CLK_OUT[0]), 0);
        step(1); chk("shadow_e8", int'(CLK_OUT[0]), 1);

        // Enable gating: ch1 div 5, paused at cnt=2 for 5 cycles
        DIVISOR = {4'd5, 4'd0};
        sync_pulse();
        step(2);
        EN = 2'b01;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("gate_frozen_clk1", int'(CLK_OUT[1]), 0);
            chk("gate_frozen_tick1", int'(TICK[1]), 0);
        end
        EN = 2'b11;
        step(3); chk("gate_pre_toggle", int'(CLK_OUT[1]), 0);
        step(1); chk("gate_toggle_clk1", int'(CLK_OUT[1]), 1); chk("gate_toggle_tick1", int'(TICK[1]), 1);

        // SYNC alignment from different phases
        DIVISOR = {4'd3, 4'd3}; EN = 2'b01;
        step(2); EN = 2'b11;
        step(3);
        sync_pulse();
        chk("sync_clk", int'(CLK_OUT), 0); chk("sync_tick", int'(TICK), 0);
        step(3); chk("sync_e3", int'(CLK_OUT), 0);
        step(1); chk("sync_e4", int'(CLK_OUT), 3); chk("sync_e4_tick", int'(TICK), 3);
        step(4); chk("sync_e8", int'(CLK_OUT), 0); chk("sync_e8_tick", int'(TICK), 3);

        // Max divisor on ch0
        DIVISOR = {4'd0, 4'd15}; EN = 2'b01;
        sync_pulse();
        ticks0 = 0; first0 = -1;
        for (int k = 1; k <= 96; k++) begin
            step(1);
            if (TICK[0]) begin
                ticks0++;
                if (first0 < 0) first0 = k;
            end
        end
        chk("max_tick_count", ticks0, 6);
        chk("max_first_tick", first0, 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
